// File: rtl/core_l1d_pkg.sv
// Shared encodings for the L1D request controller: operation codes,
// access sizes and the controller FSM state type.
package core_l1d_pkg;

  localparam logic [2:0] COP_LD = 3'd0;
  localparam logic [2:0] COP_ST = 3'd1;

  localparam logic [2:0] SIZE_B = 3'd0;
  localparam logic [2:0] SIZE_H = 3'd1;
  localparam logic [2:0] SIZE_W = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } l1d_state_t;

endpackage

// File: rtl/core_l1d_req_ctrl_if.sv
// Bundles the pipeline-side request/response signals and the cache-side
// request/ack signals. master = controller view, slave = pipeline/cache view.
interface core_l1d_req_ctrl_if;

  logic        pl_req_val;
  logic [31:0] pl_req_addr;
  logic [2:0]  pl_req_cop;
  logic [31:0] pl_req_wdata;
  logic [2:0]  pl_req_size;
  logic        pl_busy;
  logic        pl_ack;
  logic [31:0] pl_rdata;
  logic        pl_err;

  logic        l1d_req_val;
  logic [31:0] l1d_req_addr;
  logic [2:0]  l1d_req_cop;
  logic [31:0] l1d_req_wdata;
  logic [2:0]  l1d_req_size;
  logic        l1d_req_nc;
  logic        l1d_req_rdy;
  logic        l1d_ack;
  logic [31:0] l1d_rdata;

  modport master (
    input  pl_req_val, pl_req_addr, pl_req_cop, pl_req_wdata, pl_req_size,
    output pl_busy, pl_ack, pl_rdata, pl_err,
    output l1d_req_val, l1d_req_addr, l1d_req_cop, l1d_req_wdata,
    output l1d_req_size, l1d_req_nc,
    input  l1d_req_rdy, l1d_ack, l1d_rdata
  );

  modport slave (
    output pl_req_val, pl_req_addr, pl_req_cop, pl_req_wdata, pl_req_size,
    input  pl_busy, pl_ack, pl_rdata, pl_err,
    input  l1d_req_val, l1d_req_addr, l1d_req_cop, l1d_req_wdata,
    input  l1d_req_size, l1d_req_nc,
    output l1d_req_rdy, l1d_ack, l1d_rdata
  );

endinterface

// File: rtl/core_l1d_addr_chk.sv
// Combinational address checks: alignment against access size and
// membership in the CSR-programmed non-cacheable region.
module core_l1d_addr_chk
  import core_l1d_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [2:0]  size,
  input  logic [31:0] base,
  input  logic [31:0] mask,
  output logic        misalign,
  output logic        nc
);

  logic [31:0] bit_match;

  // A bit matches when it is masked out or equals the base bit.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_match
      assign bit_match[gi] = ~((addr[gi] ^ base[gi]) & mask[gi]);
    end
  endgenerate

  assign nc = &bit_match;

  // Byte accesses are always aligned; unknown sizes are treated as aligned.
  always_comb begin
    misalign = 1'b0;
    case (size)
      SIZE_H:  misalign = addr[0];
      SIZE_W:  misalign = |addr[1:0];
      default: misalign = 1'b0;
    endcase
  end

endmodule

// File: rtl/core_l1d_req_ctrl.sv
// L1D request controller: latches one pipeline request, issues it to the
// cache with valid/ready, waits for the cache ack and returns data or an
// error pulse. Every transaction is bounded by a cycle timeout.
module core_l1d_req_ctrl
  import core_l1d_pkg::*;
#(
  parameter int TIMEOUT_CYC = 256,
  parameter int CNT_W       = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          csr_nc_base,
  input  logic [31:0]          csr_nc_mask,
  core_l1d_req_ctrl_if.master  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  l1d_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [31:0]      addr_reg, wdata_reg, rdata_reg;
  logic [2:0]       cop_reg, size_reg;
  logic             nc_reg, err_reg, mis_reg;

  logic misalign, nc_hit;
  logic latch, mis_hit, tmo_hit, cap_data, tmo_fire;

  core_l1d_addr_chk u_addr_chk (
    .addr     (bus.pl_req_addr),
    .size     (bus.pl_req_size),
    .base     (csr_nc_base),
    .mask     (csr_nc_mask),
    .misalign (misalign),
    .nc       (nc_hit)
  );

  assign tmo_hit = (cnt_reg == CNT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; a completing rdy/ack beats a timeout in the same cycle.
  always_comb begin
    state_next = state_reg;
    latch      = 1'b0;
    mis_hit    = 1'b0;
    cap_data   = 1'b0;
    tmo_fire   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.pl_req_val) begin
          if (misalign) begin
            mis_hit = 1'b1;
          end else begin
            latch      = 1'b1;
            state_next = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        if (bus.l1d_req_rdy) begin
          state_next = ST_WAIT;
        end else if (tmo_hit) begin
          tmo_fire   = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_WAIT: begin
        if (bus.l1d_ack) begin
          cap_data   = 1'b1;
          state_next = ST_RESP;
        end else if (tmo_hit) begin
          tmo_fire   = 1'b1;
          state_next = ST_RESP;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Holding registers, timeout counter and response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg   <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      cop_reg   <= '0;
      size_reg  <= '0;
      nc_reg    <= 1'b0;
      err_reg   <= 1'b0;
      mis_reg   <= 1'b0;
    end else begin
      mis_reg <= mis_hit;
      if (latch) begin
        addr_reg  <= bus.pl_req_addr;
        cop_reg   <= bus.pl_req_cop;
        wdata_reg <= bus.pl_req_wdata;
        size_reg  <= bus.pl_req_size;
        nc_reg    <= nc_hit;
        cnt_reg   <= '0;
      end else if (state_reg == ST_SEND || state_reg == ST_WAIT) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (cap_data) begin
        rdata_reg <= bus.l1d_rdata;
        err_reg   <= 1'b0;
      end else if (tmo_fire) begin
        rdata_reg <= '0;
        err_reg   <= 1'b1;
      end
    end
  end

  assign bus.pl_busy       = (state_reg != ST_IDLE);
  assign bus.pl_ack        = (state_reg == ST_RESP) | mis_reg;
  assign bus.pl_err        = ((state_reg == ST_RESP) & err_reg) | mis_reg;
  assign bus.pl_rdata      = (state_reg == ST_RESP) ? rdata_reg : 32'd0;
  assign bus.l1d_req_val   = (state_reg == ST_SEND);
  assign bus.l1d_req_addr  = addr_reg;
  assign bus.l1d_req_cop   = cop_reg;
  assign bus.l1d_req_wdata = wdata_reg;
  assign bus.l1d_req_size  = size_reg;
  assign bus.l1d_req_nc    = nc_reg;

endmodule

// File: tb/tb_core_l1d_req_ctrl.sv
// Directed bench for core_l1d_req_ctrl: a table of single transactions
// plus hand-written sequences for timeout, reset and back-to-back cases.
module tb_core_l1d_req_ctrl;
  import core_l1d_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] csr_nc_base;
  logic [31:0] csr_nc_mask;
  int          total;
  int          bad;

  core_l1d_req_ctrl_if bus ();

  core_l1d_req_ctrl #(.TIMEOUT_CYC(8), .CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .csr_nc_base (csr_nc_base),
    .csr_nc_mask (csr_nc_mask),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  cop;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] mask;
    int          rdy_dly;
    int          ack_dly;
    logic [31:0] cache_data;
    logic        exp_mis;
    logic        exp_nc;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_req(input logic [2:0] cop, input logic [31:0] addr,
                           input logic [2:0] size, input logic [31:0] wdata);
    bus.pl_req_val   = 1'b1;
    bus.pl_req_cop   = cop;
    bus.pl_req_addr  = addr;
    bus.pl_req_size  = size;
    bus.pl_req_wdata = wdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=running want=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    total = 0;
    bad   = 0;

    //                cop     addr          size    wdata         mask          rdy ack cache_data    mis   nc    exp_rdata
    vecs[0] = '{COP_LD, 32'h0000_0100, SIZE_W, 32'h0,        32'hF000_0000, 0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{COP_ST, 32'hF000_0010, SIZE_W, 32'h1234_5678, 32'hF000_0000, 4, 1, 32'h0000_0055, 1'b0, 1'b1, 32'h0000_0055};
    vecs[2] = '{COP_ST, 32'h0000_0101, SIZE_H, 32'h0000_ABCD, 32'hF000_0000, 0, 0, 32'h0,         1'b1, 1'b0, 32'h0};
    vecs[3] = '{COP_LD, 32'h0000_0103, SIZE_B, 32'h0,        32'hF000_0000, 1, 0, 32'h0000_00A5, 1'b0, 1'b0, 32'h0000_00A5};
    vecs[4] = '{COP_LD, 32'h0000_0102, SIZE_W, 32'h0,        32'hF000_0000, 0, 0, 32'h0,         1'b1, 1'b0, 32'h0};
    vecs[5] = '{COP_LD, 32'hF000_0102, SIZE_H, 32'h0,        32'hF000_0000, 0, 2, 32'h0000_BEEF, 1'b0, 1'b1, 32'h0000_BEEF};
    vecs[6] = '{COP_LD, 32'h0000_0200, SIZE_W, 32'h0,        32'h0000_0000, 0, 0, 32'h1111_2222, 1'b0, 1'b1, 32'h1111_2222};

    rst              = 1'b1;
    csr_nc_base      = 32'hF000_0000;
    csr_nc_mask      = 32'hF000_0000;
    bus.pl_req_val   = 1'b0;
    bus.pl_req_addr  = '0;
    bus.pl_req_cop   = '0;
    bus.pl_req_wdata = '0;
    bus.pl_req_size  = '0;
    bus.l1d_req_rdy  = 1'b0;
    bus.l1d_ack      = 1'b0;
    bus.l1d_rdata    = '0;
    step();
    step();

    chk("rst_busy",  {31'd0, bus.pl_busy},     32'd0);
    chk("rst_ack",   {31'd0, bus.pl_ack},      32'd0);
    chk("rst_err",   {31'd0, bus.pl_err},      32'd0);
    chk("rst_rdata", bus.pl_rdata,             32'd0);
    chk("rst_val",   {31'd0, bus.l1d_req_val}, 32'd0);
    chk("rst_addr",  bus.l1d_req_addr,         32'd0);
    chk("rst_nc",    {31'd0, bus.l1d_req_nc},  32'd0);
    rst = 1'b0;
    step();

    // ---------------- table-driven single transactions ----------------
    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      csr_nc_mask = v.mask;
      drive_req(v.cop, v.addr, v.size, v.wdata);
      chk("idle_busy", {31'd0, bus.pl_busy}, 32'd0);
      step();
      bus.pl_req_val = 1'b0;
      if (v.exp_mis) begin
        chk("mis_ack",   {31'd0, bus.pl_ack},      32'd1);
        chk("mis_err",   {31'd0, bus.pl_err},      32'd1);
        chk("mis_rdata", bus.pl_rdata,             32'd0);
        chk("mis_val",   {31'd0, bus.l1d_req_val}, 32'd0);
        chk("mis_busy",  {31'd0, bus.pl_busy},     32'd0);
        step();
        chk("mis_ack_end", {31'd0, bus.pl_ack},      32'd0);
        chk("mis_val_end", {31'd0, bus.l1d_req_val}, 32'd0);
      end else begin
        for (int d = 0; d <= v.rdy_dly; d++) begin
          chk("send_val",   {31'd0, bus.l1d_req_val}, 32'd1);
          chk("send_addr",  bus.l1d_req_addr,         v.addr);
          chk("send_cop",   {29'd0, bus.l1d_req_cop}, {29'd0, v.cop});
          chk("send_wdata", bus.l1d_req_wdata,        v.wdata);
          chk("send_size",  {29'd0, bus.l1d_req_size}, {29'd0, v.size});
          chk("send_nc",    {31'd0, bus.l1d_req_nc},  {31'd0, v.exp_nc});
          chk("send_busy",  {31'd0, bus.pl_busy},     32'd1);
          chk("send_ack",   {31'd0, bus.pl_ack},      32'd0);
          if (d == v.rdy_dly) bus.l1d_req_rdy = 1'b1;
          step();
        end
        bus.l1d_req_rdy = 1'b0;
        for (int d = 0; d <= v.ack_dly; d++) begin
          chk("wait_val",  {31'd0, bus.l1d_req_val}, 32'd0);
          chk("wait_busy", {31'd0, bus.pl_busy},     32'd1);
          chk("wait_ack",  {31'd0, bus.pl_ack},      32'd0);
          if (d == v.ack_dly) begin
            bus.l1d_ack   = 1'b1;
            bus.l1d_rdata = v.cache_data;
          end
          step();
        end
        bus.l1d_ack   = 1'b0;
        bus.l1d_rdata = 32'h0BAD_0BAD;
        chk("resp_ack",   {31'd0, bus.pl_ack},  32'd1);
        chk("resp_err",   {31'd0, bus.pl_err},  32'd0);
        chk("resp_rdata", bus.pl_rdata,         v.exp_rdata);
        chk("resp_busy",  {31'd0, bus.pl_busy}, 32'd1);
        step();
        chk("post_ack",  {31'd0, bus.pl_ack},  32'd0);
        chk("post_busy", {31'd0, bus.pl_busy}, 32'd0);
      end
      $display("txn %0d addr=0x%08h size=%0d mis=%0d total=%0d bad=%0d",
               i, v.addr, v.size, v.exp_mis, total, bad);
    end
    csr_nc_mask = 32'hF000_0000;

    // ---------------- timeout with rdy never asserted, then late ack ----
    drive_req(COP_LD, 32'h0000_0300, SIZE_W, 32'h0);
    step();
    bus.pl_req_val = 1'b0;
    for (int d = 0; d < 8; d++) begin
      chk("tmo_send_val", {31'd0, bus.l1d_req_val}, 32'd1);
      chk("tmo_send_ack", {31'd0, bus.pl_ack},      32'd0);
      step();
    end
    chk("tmo_ack",   {31'd0, bus.pl_ack},      32'd1);
    chk("tmo_err",   {31'd0, bus.pl_err},      32'd1);
    chk("tmo_rdata", bus.pl_rdata,             32'd0);
    chk("tmo_val",   {31'd0, bus.l1d_req_val}, 32'd0);
    step();
    chk("tmo_ack_end", {31'd0, bus.pl_ack},      32'd0);
    chk("tmo_val_end", {31'd0, bus.l1d_req_val}, 32'd0);
    step();
    step();
    bus.l1d_ack   = 1'b1;
    bus.l1d_rdata = 32'h7777_7777;
    step();
    bus.l1d_ack = 1'b0;
    chk("late_ack",  {31'd0, bus.pl_ack},      32'd0);
    chk("late_busy", {31'd0, bus.pl_busy},     32'd0);
    chk("late_val",  {31'd0, bus.l1d_req_val}, 32'd0);
    step();
    chk("late_ack2", {31'd0, bus.pl_ack}, 32'd0);
    $display("txn timeout total=%0d bad=%0d", total, bad);

    // ---------------- ack together with rdy is not honoured -------------
    drive_req(COP_LD, 32'h0000_0500, SIZE_W, 32'h0);
    step();
    bus.pl_req_val  = 1'b0;
    bus.l1d_req_rdy = 1'b1;
    bus.l1d_ack     = 1'b1;
    bus.l1d_rdata   = 32'hAAAA_0001;
    step();
    bus.l1d_req_rdy = 1'b0;
    bus.l1d_ack     = 1'b0;
    chk("early_ack_busy", {31'd0, bus.pl_busy}, 32'd1);
    step();
    chk("early_ack_none", {31'd0, bus.pl_ack}, 32'd0);
    bus.l1d_ack   = 1'b1;
    bus.l1d_rdata = 32'hAAAA_0002;
    step();
    bus.l1d_ack = 1'b0;
    chk("early_resp_ack",   {31'd0, bus.pl_ack}, 32'd1);
    chk("early_resp_rdata", bus.pl_rdata,        32'hAAAA_0002);
    step();
    $display("txn early_ack total=%0d bad=%0d", total, bad);

    // ---------------- rdy in the timeout cycle, then reset in WAIT ------
    drive_req(COP_LD, 32'h0000_0600, SIZE_W, 32'h0);
    step();
    bus.pl_req_val = 1'b0;
    for (int d = 0; d < 7; d++) step();
    chk("edge_val", {31'd0, bus.l1d_req_val}, 32'd1);
    bus.l1d_req_rdy = 1'b1;
    step();
    bus.l1d_req_rdy = 1'b0;
    chk("edge_ack",  {31'd0, bus.pl_ack},      32'd0);
    chk("edge_err",  {31'd0, bus.pl_err},      32'd0);
    chk("edge_busy", {31'd0, bus.pl_busy},     32'd1);
    chk("edge_val2", {31'd0, bus.l1d_req_val}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstw_busy", {31'd0, bus.pl_busy},     32'd0);
    chk("rstw_ack",  {31'd0, bus.pl_ack},      32'd0);
    chk("rstw_val",  {31'd0, bus.l1d_req_val}, 32'd0);
    step();
    chk("rstw_ack2", {31'd0, bus.pl_ack},  32'd0);
    chk("rstw_busy2", {31'd0, bus.pl_busy}, 32'd0);
    $display("txn rdy_at_timeout_then_rst total=%0d bad=%0d", total, bad);

    // ---------------- back-to-back with request held through busy -------
    drive_req(COP_LD, 32'h0000_0400, SIZE_W, 32'h0);
    step();
    drive_req(COP_ST, 32'h0000_0404, SIZE_W, 32'hCAFE_F00D);
    chk("b2b_a_addr", bus.l1d_req_addr, 32'h0000_0400);
    bus.l1d_req_rdy = 1'b1;
    step();
    bus.l1d_req_rdy = 1'b0;
    bus.l1d_ack     = 1'b1;
    bus.l1d_rdata   = 32'h0000_AAAA;
    step();
    bus.l1d_ack = 1'b0;
    chk("b2b_a_ack",   {31'd0, bus.pl_ack}, 32'd1);
    chk("b2b_a_rdata", bus.pl_rdata,        32'h0000_AAAA);
    step();
    chk("b2b_gap_busy", {31'd0, bus.pl_busy}, 32'd0);
    chk("b2b_gap_ack",  {31'd0, bus.pl_ack},  32'd0);
    step();
    bus.pl_req_val = 1'b0;
    chk("b2b_b_val",   {31'd0, bus.l1d_req_val}, 32'd1);
    chk("b2b_b_addr",  bus.l1d_req_addr,         32'h0000_0404);
    chk("b2b_b_wdata", bus.l1d_req_wdata,        32'hCAFE_F00D);
    chk("b2b_b_cop",   {29'd0, bus.l1d_req_cop}, {29'd0, COP_ST});
    bus.l1d_req_rdy = 1'b1;
    step();
    bus.l1d_req_rdy = 1'b0;
    bus.l1d_ack     = 1'b1;
    bus.l1d_rdata   = 32'h0000_BBBB;
    step();
    bus.l1d_ack = 1'b0;
    chk("b2b_b_ack",   {31'd0, bus.pl_ack}, 32'd1);
    chk("b2b_b_rdata", bus.pl_rdata,        32'h0000_BBBB);
    step();
    chk("b2b_end_busy", {31'd0, bus.pl_busy}, 32'd0);
    $display("txn back_to_back total=%0d bad=%0d", total, bad);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
